// File: rtl/count_display_driver_if.sv
// Bundle for count_display_driver: value to display, converter status and
// the registered digit-drive outputs.
interface count_display_driver_if;
  logic [7:0]  count;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        busy;
  logic [11:0] bcd;

  modport master (
    output count,
    input  an, seg, dp, busy, bcd
  );

  modport slave (
    input  count,
    output an, seg, dp, busy, bcd
  );
endinterface

// File: rtl/count_display_driver.sv
// Binary-to-BCD (double dabble) converter driving a 3-digit multiplexed 7-segment display.
// Define LEADING_ZERO_BLANK_EN to blank leading zero hundreds/tens digits.
module count_display_driver #(
  parameter int unsigned REFRESH_DIV = 20000
) (
  input  logic                  clk,
  input  logic                  reset,
  count_display_driver_if.slave bus
);

  localparam logic [15:0] REFRESH_MAX = 16'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state, state_nxt;
  logic [7:0]  sampled, sampled_nxt;
  logic [7:0]  shreg, shreg_nxt;
  logic [11:0] scratch, scratch_nxt, scratch_adj;
  logic [2:0]  bit_cnt, bit_cnt_nxt;
  logic        pending, pending_nxt;
  logic        busy_r, busy_nxt;
  logic [11:0] bcd_r, bcd_nxt;

  logic [15:0] refresh_cnt;
  logic [1:0]  digit_sel;
  logic [3:0]  nibble;
  logic [3:0]  an_nxt, an_r;
  logic [6:0]  seg_r;
  logic        dp_r;

  function automatic logic [11:0] dabble_adjust(input logic [11:0] v);
    logic [11:0] r;
    for (int i = 0; i < 3; i++) begin
      r[i*4 +: 4] = (v[i*4 +: 4] >= 4'd5) ? v[i*4 +: 4] + 4'd3 : v[i*4 +: 4];
    end
    return r;
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  assign scratch_adj = dabble_adjust(scratch);

  // Converter state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      sampled <= 8'd0;
      shreg   <= 8'd0;
      scratch <= 12'd0;
      bit_cnt <= 3'd0;
      pending <= 1'b1;
      busy_r  <= 1'b0;
      bcd_r   <= 12'h000;
    end else begin
      state   <= state_nxt;
      sampled <= sampled_nxt;
      shreg   <= shreg_nxt;
      scratch <= scratch_nxt;
      bit_cnt <= bit_cnt_nxt;
      pending <= pending_nxt;
      busy_r  <= busy_nxt;
      bcd_r   <= bcd_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    sampled_nxt = sampled;
    shreg_nxt   = shreg;
    scratch_nxt = scratch;
    bit_cnt_nxt = bit_cnt;
    pending_nxt = pending;
    busy_nxt    = busy_r;
    bcd_nxt     = bcd_r;
    case (state)
      IDLE: begin
        if ((bus.count != sampled) || pending) begin
          sampled_nxt = bus.count;
          shreg_nxt   = bus.count;
          pending_nxt = 1'b0;
          scratch_nxt = 12'd0;
          bit_cnt_nxt = 3'd0;
          busy_nxt    = 1'b1;
          state_nxt   = SHIFT;
        end
      end
      SHIFT: begin
        // Add-3 correction and shift happen in the same cycle
        scratch_nxt = {scratch_adj[10:0], shreg[7]};
        shreg_nxt   = {shreg[6:0], 1'b0};
        bit_cnt_nxt = bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) state_nxt = DONE;
      end
      DONE: begin
        bcd_nxt   = scratch;
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Refresh timing and digit select
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      refresh_cnt <= 16'd0;
      digit_sel   <= 2'd0;
    end else if (refresh_cnt == REFRESH_MAX) begin
      refresh_cnt <= 16'd0;
      digit_sel   <= (digit_sel == 2'd2) ? 2'd0 : digit_sel + 2'd1;
    end else begin
      refresh_cnt <= refresh_cnt + 16'd1;
    end
  end

  always_comb begin
    nibble = bcd_r[3:0];
    an_nxt = 4'b1110;
    case (digit_sel)
      2'd1: begin
        nibble = bcd_r[7:4];
        an_nxt = 4'b1101;
      end
      2'd2: begin
        nibble = bcd_r[11:8];
        an_nxt = 4'b1011;
      end
      default: ;
    endcase
`ifdef LEADING_ZERO_BLANK_EN
    if ((digit_sel == 2'd2) && (bcd_r[11:8] == 4'd0)) an_nxt = 4'b1111;
    if ((digit_sel == 2'd1) && (bcd_r[11:4] == 8'd0)) an_nxt = 4'b1111;
`endif
  end

  // Registered display drive
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_r  <= 4'b1111;
      seg_r <= 7'b1111111;
      dp_r  <= 1'b1;
    end else begin
      an_r  <= an_nxt;
      seg_r <= seg_decode(nibble);
      dp_r  <= 1'b1;
    end
  end

  assign bus.an   = an_r;
  assign bus.seg  = seg_r;
  assign bus.dp   = dp_r;
  assign bus.busy = busy_r;
  assign bus.bcd  = bcd_r;

endmodule

// File: tb/tb_count_display_driver.sv
// Randomized and directed bench for count_display_driver against a cycle-level
// behavioural model using decimal arithmetic.
module tb_count_display_driver;
  localparam int DIV = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  count_display_driver_if ifc ();

  count_display_driver #(.REFRESH_DIV(DIV)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (ifc)
  );

  int checks = 0;
  int errors = 0;

  int m_n, m_left, m_last, m_latched, m_val;
  bit m_pending;
  int busy_rises = 0;
  logic prev_busy = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic model_reset();
    m_n = 0; m_left = 0; m_last = 0; m_latched = 0; m_val = 0; m_pending = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_an"},   32'(ifc.an),   32'hF);
    chk({tag, "_seg"},  32'(ifc.seg),  32'h7F);
    chk({tag, "_dp"},   32'(ifc.dp),   32'h1);
    chk({tag, "_busy"}, 32'(ifc.busy), 32'h0);
    chk({tag, "_bcd"},  32'(ifc.bcd),  32'h0);
  endtask

  // One clock: advance the model on the edge, then compare 1 time unit later.
  task automatic cycle();
    int sel, shown, digit;
    logic [3:0] e_an;
    sel = 0; digit = 0; e_an = 4'hF;
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      m_n++;
      shown = m_val;
      sel   = ((m_n - 1) / DIV) % 3;
      digit = (sel == 0) ? shown % 10 : (sel == 1) ? (shown / 10) % 10 : shown / 100;
      e_an  = (sel == 0) ? 4'b1110 : (sel == 1) ? 4'b1101 : 4'b1011;
`ifdef LEADING_ZERO_BLANK_EN
      if (sel == 2 && shown < 100) e_an = 4'b1111;
      if (sel == 1 && shown < 10)  e_an = 4'b1111;
`endif
      if (m_left != 0) begin
        m_left--;
        if (m_left == 0) m_val = m_latched;
      end else if ((int'(ifc.count) != m_last) || m_pending) begin
        m_last = int'(ifc.count);
        m_latched = m_last;
        m_pending = 1'b0;
        m_left = 9;
      end
    end
    #1;
    if (reset) begin
      check_reset_outputs("rst_hold");
    end else begin
      chk("an",   32'(ifc.an),   32'(e_an));
      chk("seg",  32'(ifc.seg),  32'(seg_of(digit)));
      chk("dp",   32'(ifc.dp),   32'h1);
      chk("busy", 32'(ifc.busy), 32'(m_left != 0));
      chk("bcd",  32'(ifc.bcd),  32'(to_bcd(m_val)));
    end
    if (ifc.busy && !prev_busy) busy_rises++;
    prev_busy = ifc.busy;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    reset = 1'b0;
    ifc.count = 8'd0;
    model_reset();
    #1 reset = 1'b1;
    #2 check_reset_outputs("rst_async");
    run(2);
    reset = 1'b0;

    // count 0 held: first conversion from the pending flag, digits cycle
    run(30);

    // full-scale value
    ifc.count = 8'd255;
    run(25);

    // second value arrives while the first conversion is busy
    ifc.count = 8'd37;
    run(3);
    ifc.count = 8'd142;
    run(30);

    // reset mid-conversion aborts; pending flag reconverts afterwards
    ifc.count = 8'd99;
    run(5);
    reset = 1'b1;
    #1 check_reset_outputs("rst_mid");
    model_reset();
    run(2);
    reset = 1'b0;
    run(25);

    // single-digit value exercises leading-zero handling
    ifc.count = 8'd7;
    run(20);

    // steady input converts only once
    ifc.count = 8'd200;
    busy_rises = 0;
    run(100);
    chk("one_conversion", 32'(busy_rises), 32'd1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) ifc.count = 8'($urandom_range(0, 255));
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
